noc_link_port: RTL

- Point-to-point link port between a source NI's transmit side and a destination NI's receive side.
- Ingress: accepts parity-protected flits on source req; drives the source's channel_busy/send_en flow control.
- Checks parity and destination address, buffers good flits in a small FIFO.
- Egress: presents flits to the destination NI as single-cycle valid pulses, paced by that NI's busy.

---
 rtl/noc_link_port_pkg.sv | 15 +
 rtl/noc_flit_fifo.sv | 52 +++++
 rtl/noc_link_port.sv | 124 ++++++++++++
 3 files changed

// File: rtl/noc_link_port_pkg.sv
// Shared defaults and egress state encoding for the NoC link port.
package noc_link_port_pkg;

  localparam int unsigned HdrSzDef  = 4;
  localparam int unsigned PlSzDef   = 16;
  localparam int unsigned AddrSzDef = 4;
  localparam int unsigned DepthDef  = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StPresent = 2'd1,
    StHold    = 2'd2
  } egress_state_e;

endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous FIFO holding accepted flits; pointers wrap modulo Depth.
module noc_flit_fifo
  import noc_link_port_pkg::*;
#(
  parameter int unsigned Width = 24,
  parameter int unsigned Depth = DepthDef,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  // Storage array; no reset needed, validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/noc_link_port.sv
// Link port: parity/address screening on ingress, FIFO buffering, and a
// paced single-pulse egress towards the destination NI.
module noc_link_port
  import noc_link_port_pkg::*;
#(
  parameter int unsigned HDR_SZ  = HdrSzDef,
  parameter int unsigned PL_SZ   = PlSzDef,
  parameter int unsigned ADDR_SZ = AddrSzDef,
  parameter int unsigned DEPTH   = DepthDef,
  localparam int unsigned W      = HDR_SZ + PL_SZ + ADDR_SZ,
  localparam int unsigned CntW   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_SZ-1:0] port_id,
  input  logic [W-1:0]       src_item,
  input  logic               src_req,
  output logic               src_channel_busy,
  output logic               src_send_en,
  output logic [W-1:0]       dst_item,
  output logic               dst_valid,
  input  logic               dst_busy,
  output logic               parity_err,
  output logic               misroute,
  output logic               overflow,
  output logic [7:0]         drop_cnt
);

  logic            parity_ok, addr_ok, can_accept, push, pop, drop;
  logic [W-1:0]    fifo_rdata;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] count;

  egress_state_e state_q, state_d;
  logic [W-1:0]  dst_item_q, dst_item_d;
  logic          dst_valid_q, dst_valid_d;
  logic          parity_err_q, misroute_q, overflow_q;
  logic [7:0]    drop_cnt_q;

  assign parity_ok  = (src_item[W-1] == ^src_item[W-2:0]);
  assign addr_ok    = (src_item[ADDR_SZ-1:0] == port_id);
  // A pop in the same cycle frees the head slot, so a full FIFO can still take a flit.
  assign can_accept = !fifo_full || pop;
  assign push       = src_req && parity_ok && addr_ok && can_accept;
  assign drop       = src_req && !push;

  noc_flit_fifo #(
    .Width (W),
    .Depth (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (src_item),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  // One slot is reserved for a flit the source may already have committed.
  assign src_channel_busy = (count >= CntW'(DEPTH - 1));
  assign src_send_en      = !src_channel_busy;

  // Sticky drop flags and saturating drop counter; first failing check wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err_q <= 1'b0;
      misroute_q   <= 1'b0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= 8'd0;
    end else if (drop) begin
      if (!parity_ok)    parity_err_q <= 1'b1;
      else if (!addr_ok) misroute_q   <= 1'b1;
      else               overflow_q   <= 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  // Egress state and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      dst_item_q  <= '0;
      dst_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dst_item_q  <= dst_item_d;
      dst_valid_q <= dst_valid_d;
    end
  end

  // Egress next-state: load and pulse from IDLE, then wait out the busy gap in HOLD.
  always_comb begin
    state_d     = state_q;
    dst_item_d  = dst_item_q;
    dst_valid_d = 1'b0;
    pop         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && !dst_busy) begin
          pop         = 1'b1;
          dst_item_d  = fifo_rdata;
          dst_valid_d = 1'b1;
          state_d     = StPresent;
        end
      end
      StPresent: state_d = StHold;
      StHold: begin
        if (!dst_busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign dst_item   = dst_item_q;
  assign dst_valid  = dst_valid_q;
  assign parity_err = parity_err_q;
  assign misroute   = misroute_q;
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
